pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central pipeline controller for the five-stage core. It decides every cycle whether each pipeline register (PC, IF_ID, ID_EX, EX_MEM, MEM_WB) loads, holds or takes a bubble. Inputs are load-use and RAW hazards, branch/jump redirects resolved in EX, and a data-memory ready handshake. A small state machine tracks multi-cycle memory waits, halts the core on a memory timeout, and keeps stall and flush performance counters.

## Interface
- CNT_W, 32, width of the saturating performance counters
- MEM_TIMEOUT, 64, consecutive unready memory cycles before HALT (≥2)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_rs1_addr, id_rs2_addr  in  5  source registers of the instruction in ID
- id_rs1_used, id_rs2_used  in  1  source actually read by the ID instruction
- ex_reg_write  in  1  EX instruction writes rd
- ex_mem_read  in  1  EX instruction is a load
- ex_rd_addr  in  5  EX destination register
- mem_reg_write  in  1  MEM instruction writes rd
- mem_rd_addr  in  5  MEM destination register
- ex_branch_taken  in  1  EX redirects PC (taken branch, jal, jalr)
- mem_req  in  1  MEM stage is accessing data memory
- mem_ready  in  1  data memory completes the access this cycle
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  register loads on next edge
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1  register loads a bubble (all zero) on next edge; overrides its en
- mem_err  out  1  core halted on memory timeout
- stall_cycles  out  CNT_W  cycles with pc_en=0 outside HALT
- flush_count  out  CNT_W  branch flush events

## Operation
- State register: RUN, MEM_WAIT, HALT. A wait counter wait_cnt (clog2(MEM_TIMEOUT)+1 bits) counts consecutive cycles in which mem_req=1 and mem_ready=0.
  - RUN→MEM_WAIT: mem_req & !mem_ready.
  - MEM_WAIT→RUN: mem_ready or !mem_req. wait_cnt clears.
  - MEM_WAIT→HALT: wait_cnt reaches MEM_TIMEOUT-1 while mem_req & !mem_ready.
  - HALT is sticky until rst.
- Outputs are combinational from state and inputs, evaluated in priority order (highest first):
  1. rst=1: all en=0, all flush=1, pc_en=0.
  2. HALT: all en=0, all flush=0. Everything frozen.
  3. Memory freeze (mem_req & !mem_ready, any non-HALT state): pc_en, if_id_en, id_ex_en, ex_mem_en=0; mem_wb_flush=1.
  4. Branch (ex_branch_taken): pc_en=1, if_id_flush=1, id_ex_flush=1, the rest en=1. flush_count increments.
  5. Data hazard: pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=mem_wb_en=1.
  6. Otherwise all en=1, all flush=0.
- Source match: (id_rs1_used & addr==id_rs1_addr) | (id_rs2_used & addr==id_rs2_addr), with addr≠0. x0 never hazards.
- A branch that coincides with a freeze is not lost. EX is held, so ex_branch_taken stays asserted and the flush takes effect in the cycle the freeze lifts. flush_count counts it once.
- Branch beats hazard: the stalled ID instruction is wrong-path and is flushed.
- Counters saturate at 2^CNT_W-1. stall_cycles does not count in HALT or during rst.

## Timing
- All control outputs are zero-latency combinational. State and counters update on the rising edge.
- Reset values after rst deasserts: state=RUN, wait_cnt=0, mem_err=0, stall_cycles=0, flush_count=0. Outputs then follow rule 6 unless inputs demand otherwise.
- rst mid-operation, including in HALT or MEM_WAIT: returns to RUN on the next edge, counters zero.
- A load-use hazard produces exactly one stall cycle with forwarding. A hazard on an instruction in EX produces two stall cycles without forwarding.
- mem_ready arriving in the same cycle as mem_req means no freeze and no state change.

## Configuration
- PIPE_CTRL_FORWARD_EN defined: a data hazard is only ex_mem_read & ex_reg_write & source match on ex_rd_addr. The EX/MEM forwarding network covers everything else. mem_reg_write and mem_rd_addr are ignored.
- PIPE_CTRL_FORWARD_EN undefined: a data hazard is (ex_reg_write & match ex_rd_addr) | (mem_reg_write & match mem_rd_addr). The register file is write-before-read, so WB never hazards.

## Test plan
- Load-use (forward on): ex_mem_read=1, ex_rd_addr=5, id_rs1_addr=5, id_rs1_used=1 for one cycle → pc_en=0, if_id_en=0, id_ex_flush=1; stall_cycles 0→1. Same with ex_rd_addr=0 → no stall.
- RAW without forwarding: add writes x7 in EX, ID reads x7 → two stall cycles (EX match, then MEM match), then release; stall_cycles=2.
- Branch while hazard: ex_branch_taken=1 together with a load-use match → pc_en=1, if_id_flush=id_ex_flush=1, no stall; flush_count=1.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then ready → three cycles of freeze with mem_wb_flush=1, state RUN→MEM_WAIT→RUN, stall_cycles=3. ex_branch_taken held during the freeze → flush_count increments once, after release.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 → HALT after 4 unready cycles, mem_err=1, all en=0, counters frozen. mem_ready then rising → still halted.
- Reset from HALT: rst=1 for one cycle → all flush=1 during rst. Next cycle RUN, mem_err=0, both counters 0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: per-cycle load/hold/bubble control for the five-stage core, memory-wait FSM and perf counters.
// Define PIPE_CTRL_FORWARD_EN when the EX/MEM forwarding network is present (only load-use then stalls).
module pipeline_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd_addr,
    input  logic             mem_reg_write,
    input  logic [4:0]       mem_rd_addr,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);
    localparam int WC_W = $clog2(MEM_TIMEOUT) + 1;

    typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

    state_t           state_q, state_d;
    logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
    logic             mem_err_q, mem_err_d;
    logic             halted, freeze, branch, hazard;
    logic [8:0]       ctl;

    function automatic logic src_match(input logic [4:0] a);
        return a != 5'd0 && ((id_rs1_used && a == id_rs1_addr) || (id_rs2_used && a == id_rs2_addr));
    endfunction

    assign halted = state_q == HALT;
    assign freeze = mem_req && !mem_ready && !halted;
    assign branch = ex_branch_taken && !halted && !freeze;

`ifdef PIPE_CTRL_FORWARD_EN
    logic unused_mem;
    assign unused_mem = ^{mem_reg_write, mem_rd_addr};
    assign hazard = ex_mem_read && ex_reg_write && src_match(ex_rd_addr);
`else
    assign hazard = (ex_reg_write && src_match(ex_rd_addr)) || (mem_reg_write && src_match(mem_rd_addr));
`endif

    // {pc, if_id, id_ex, ex_mem, mem_wb enables, if_id, id_ex, ex_mem, mem_wb flushes}
    always_comb begin
        ctl = rst    ? 9'b00000_1111 :
              halted ? 9'b00000_0000 :
              freeze ? 9'b00001_0001 :
              branch ? 9'b11111_1100 :
              hazard ? 9'b00111_0100 :
                       9'b11111_0000;
    end

    assign {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
            if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush} = ctl;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        if (state_q == RUN && freeze) begin
            state_d    = MEM_WAIT;
            wait_cnt_d = WC_W'(1);
        end else if (state_q == MEM_WAIT) begin
            if (!freeze)
                state_d = RUN;
            else if (wait_cnt_q == WC_W'(MEM_TIMEOUT - 1))
                state_d = HALT;
            else
                wait_cnt_d = wait_cnt_q + WC_W'(1);
        end
        mem_err_d = state_d == HALT;
        stall_d   = (!halted && !pc_en && !(&stall_q)) ? stall_q + CNT_W'(1) : stall_q;
        flush_d   = (branch && !(&flush_q)) ? flush_q + CNT_W'(1) : flush_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
            stall_q    <= '0;
            flush_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
            stall_q    <= stall_d;
            flush_q    <= flush_d;
        end
    end

    assign mem_err      = mem_err_q;
    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: table-driven vectors plus timeout and counter-saturation sequences for pipeline_ctrl.
module tb_pipeline_ctrl;
    localparam int CNT_W = 4;
    localparam int MEM_TIMEOUT = 4;
`ifdef PIPE_CTRL_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam logic [8:0] C_RST = 9'b00000_1111;
    localparam logic [8:0] C_HLT = 9'b00000_0000;
    localparam logic [8:0] C_FRZ = 9'b00001_0001;
    localparam logic [8:0] C_BR  = 9'b11111_1100;
    localparam logic [8:0] C_HZ  = 9'b00111_0100;
    localparam logic [8:0] C_RUN = 9'b11111_0000;
    localparam logic [8:0] C_RAW = FWD ? C_RUN : C_HZ;
    localparam int R = FWD ? 0 : 1;
    localparam int S = 2 + 2 * R;

    typedef struct {
        logic       rst;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic       exw;
        logic       exr;
        logic [4:0] exd;
        logic       mw;
        logic [4:0] md;
        logic       br;
        logic       req;
        logic       rdy;
        logic [8:0] ctl;
        logic       err;
        int         st;
        int         fc;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr, mem_rd_addr;
    logic id_rs1_used, id_rs2_used, ex_reg_write, ex_mem_read, mem_reg_write;
    logic ex_branch_taken, mem_req, mem_ready;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, mem_err;
    logic [CNT_W-1:0] stall_cycles, flush_count;
    int checks = 0;
    int errors = 0;
    vec_t tbl[25];

    always #5 clk = ~clk;

    pipeline_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
        .mem_reg_write(mem_reg_write), .mem_rd_addr(mem_rd_addr),
        .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
        .mem_err(mem_err), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    // Argument order: rst, rs1, u1, rs2, u2, exw, exr, exd, mw, md, br, req, rdy, expected ctl, err, stall, flush.
    function automatic vec_t mk(input int a_rst, input int rs1, input int u1, input int rs2, input int u2,
                                input int exw, input int exr, input int exd, input int mw, input int md,
                                input int br, input int req, input int rdy,
                                input logic [8:0] ctl, input int err, input int st, input int fc);
        vec_t v;
        v.rst = a_rst != 0; v.rs1 = 5'(rs1); v.u1 = u1 != 0; v.rs2 = 5'(rs2); v.u2 = u2 != 0;
        v.exw = exw != 0; v.exr = exr != 0; v.exd = 5'(exd); v.mw = mw != 0; v.md = 5'(md);
        v.br = br != 0; v.req = req != 0; v.rdy = rdy != 0;
        v.ctl = ctl; v.err = err != 0; v.st = st; v.fc = fc;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input string nm, input int idx);
        @(negedge clk);
        rst = v.rst; id_rs1_addr = v.rs1; id_rs1_used = v.u1; id_rs2_addr = v.rs2; id_rs2_used = v.u2;
        ex_reg_write = v.exw; ex_mem_read = v.exr; ex_rd_addr = v.exd;
        mem_reg_write = v.mw; mem_rd_addr = v.md;
        ex_branch_taken = v.br; mem_req = v.req; mem_ready = v.rdy;
        #1;
        chk({nm, ".ctl"}, idx, int'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                                     if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush}), int'(v.ctl));
        chk({nm, ".mem_err"}, idx, int'(mem_err), int'(v.err));
        chk({nm, ".stall_cycles"}, idx, int'(stall_cycles), v.st);
        chk({nm, ".flush_count"}, idx, int'(flush_count), v.fc);
    endtask

    initial begin
        rst = 1'b1; id_rs1_addr = '0; id_rs2_addr = '0; id_rs1_used = 0; id_rs2_used = 0;
        ex_reg_write = 0; ex_mem_read = 0; ex_rd_addr = '0; mem_reg_write = 0; mem_rd_addr = '0;
        ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
        tbl[0]  = mk(1, 0,0,0,0, 0,0,0, 0,0, 0,0,0, C_RST, 0, 0, 0);
        tbl[1]  = mk(0, 0,0,0,0, 0,0,0, 0,0, 0,0,0, C_RUN, 0, 0, 0);
        tbl[2]  = mk(0, 5,1,0,0, 1,1,5, 0,0, 0,0,0, C_HZ,  0, 0, 0);
        tbl[3]  = mk(0, 0,0,0,0, 0,0,0, 0,0, 0,0,0, C_RUN, 0, 1, 0);
        tbl[4]  = mk(0, 0,1,0,0, 1,1,0, 0,0, 0,0,0, C_RUN, 0, 1, 0);
        tbl[5]  = mk(0, 5,0,0,0, 1,1,5, 0,0, 0,0,0, C_RUN, 0, 1, 0);
        tbl[6]  = mk(0, 0,0,9,1, 1,1,9, 0,0, 0,0,0, C_HZ,  0, 1, 0);
        tbl[7]  = mk(0, 0,0,0,0, 0,0,0, 0,0, 0,0,0, C_RUN, 0, 2, 0);
        tbl[8]  = mk(0, 7,1,0,0, 1,0,7, 0,0, 0,0,0, C_RAW, 0, 2, 0);
        tbl[9]  = mk(0, 7,1,0,0, 0,0,0, 1,7, 0,0,0, C_RAW, 0, 2 + R, 0);
        tbl[10] = mk(0, 0,0,0,0, 0,0,0, 0,0, 0,0,0, C_RUN, 0, S, 0);
        tbl[11] = mk(0, 5,1,0,0, 1,1,5, 0,0, 1,0,0, C_BR,  0, S, 0);
        tbl[12] = mk(0, 0,0,0,0, 0,0,0, 0,0, 0,0,0, C_RUN, 0, S, 1);
        tbl[13] = mk(0, 0,0,0,0, 0,0,0, 0,0, 1,1,0, C_FRZ, 0, S, 1);
        tbl[14] = mk(0, 0,0,0,0, 0,0,0, 0,0, 1,1,0, C_FRZ, 0, S + 1, 1);
        tbl[15] = mk(0, 0,0,0,0, 0,0,0, 0,0, 1,1,0, C_FRZ, 0, S + 2, 1);
        tbl[16] = mk(0, 0,0,0,0, 0,0,0, 0,0, 1,1,1, C_BR,  0, S + 3, 1);
        tbl[17] = mk(0, 0,0,0,0, 0,0,0, 0,0, 0,0,0, C_RUN, 0, S + 3, 2);
        tbl[18] = mk(0, 0,0,0,0, 0,0,0, 0,0, 0,1,1, C_RUN, 0, S + 3, 2);
        tbl[19] = mk(0, 0,0,0,0, 0,0,0, 0,0, 0,0,0, C_RUN, 0, S + 3, 2);
        tbl[20] = mk(0, 5,1,0,0, 1,1,5, 0,0, 0,1,0, C_FRZ, 0, S + 3, 2);
        tbl[21] = mk(0, 5,1,0,0, 1,1,5, 0,0, 0,0,0, C_HZ,  0, S + 4, 2);
        tbl[22] = mk(0, 0,0,0,0, 0,0,0, 0,0, 0,0,0, C_RUN, 0, S + 5, 2);
        tbl[23] = mk(1, 5,1,0,0, 1,1,5, 0,0, 1,1,0, C_RST, 0, S + 5, 2);
        tbl[24] = mk(0, 0,0,0,0, 0,0,0, 0,0, 0,0,0, C_RUN, 0, 0, 0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 25; i++) run(tbl[i], "vec", i);

        // Timeout: four unready cycles reach HALT, which then ignores everything but rst.
        run(mk(1, 0,0,0,0, 0,0,0, 0,0, 0,0,0, C_RST, 0, 0, 0), "to_rst", 0);
        for (int k = 0; k < 4; k++) run(mk(0, 0,0,0,0, 0,0,0, 0,0, 0,1,0, C_FRZ, 0, k, 0), "to_wait", k);
        run(mk(0, 0,0,0,0, 0,0,0, 0,0, 0,1,0, C_HLT, 1, 4, 0), "to_halt", 0);
        for (int k = 0; k < 3; k++) run(mk(0, 5,1,0,0, 1,1,5, 0,0, 1,1,1, C_HLT, 1, 4, 0), "halt_hold", k);
        run(mk(1, 0,0,0,0, 0,0,0, 0,0, 0,0,0, C_RST, 1, 4, 0), "halt_rst", 0);
        run(mk(0, 0,0,0,0, 0,0,0, 0,0, 0,0,0, C_RUN, 0, 0, 0), "after_rst", 0);

        // Saturation of both 4-bit counters.
        run(mk(1, 0,0,0,0, 0,0,0, 0,0, 0,0,0, C_RST, 0, 0, 0), "sat_rst", 0);
        for (int k = 0; k < 18; k++)
            run(mk(0, 3,1,0,0, 1,1,3, 0,0, 0,0,0, C_HZ, 0, (k < 15) ? k : 15, 0), "sat_stall", k);
        for (int k = 0; k < 18; k++)
            run(mk(0, 0,0,0,0, 0,0,0, 0,0, 1,0,0, C_BR, 0, 15, (k < 15) ? k : 15), "sat_flush", k);
        run(mk(0, 0,0,0,0, 0,0,0, 0,0, 0,0,0, C_RUN, 0, 15, 15), "sat_end", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
